// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial/parallel word converters.
package sipo_pkg;

  localparam int SIPO_MAX_WIDTH = 64;

  // Bits needed to hold a bit count in the range 0..width.
  function automatic int sipo_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter with bit-order steering; flags the edge that
// completes a word and presents the assembled word combinationally.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1,
  parameter int CW        = sipo_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shift,
  input  logic             i_a,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_word,
  output logic             o_done,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_sreg_next;

  // After WIDTH shifts the first bit has walked to the end LSB_FIRST selects.
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign w_sreg_next = {i_a, r_sreg[WIDTH-1:1]};
    end else begin : g_msb
      assign w_sreg_next = {r_sreg[WIDTH-2:0], i_a};
    end
  endgenerate

  assign o_done  = i_shift && !i_start && (r_count == LAST);
  assign o_word  = w_sreg_next;
  assign o_count = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg  <= '0;
      r_count <= '0;
    end else begin
      if (i_shift) r_sreg <= w_sreg_next;
      if (i_start)      r_count <= i_shift ? CW'(1) : '0;
      else if (o_done)  r_count <= '0;
      else if (i_shift) r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_word.sv
// Serial-in / parallel-out word assembler with a registered holding buffer,
// valid/ready hand-off and a sticky overflow flag for dropped words.
module sipo_word
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         shift,
  input  logic                         a,
  input  logic                         start,
  output logic [WIDTH-1:0]             out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sipo_cnt_w(WIDTH)-1:0] count,
  output logic                         overflow
);

  logic [WIDTH-1:0] w_word;
  logic             w_done;
  logic             w_free;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_ovf;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_core (
    .clk     (clk),
    .rst_n   (reset),
    .i_shift (shift),
    .i_a     (a),
    .i_start (start),
    .o_word  (w_word),
    .o_done  (w_done),
    .o_count (count)
  );

  // A buffer being consumed this edge can take the new word without a bubble.
  assign w_free = !r_valid || out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_done) begin
      if (w_free) begin
        r_out   <= w_word;
        r_valid <= 1'b1;
      end else begin
        r_ovf   <= 1'b1;
      end
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign overflow  = r_ovf;

endmodule

// File: doc/sipo_word.md
# sipo_word

Parametrised serial-in / parallel-out word assembler for the serial-adder datapath. It collects WIDTH serial bits, qualified by `shift`, into a word and hands the word off through a registered output buffer with a valid/ready handshake. A new word can be shifted in while the previous one waits to be consumed. It is the generalised successor of the fixed 4-bit SIPO and adds:
- configurable width and bit order
- frame realignment
- backpressure
- overflow detection

## Interface
Parameters:
- `WIDTH`, default 4: word width in bits; legal range 2..64.
- `LSB_FIRST`, default 1: 1 = first received bit lands in `out[0]`; 0 = first bit lands in `out[WIDTH-1]`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `shift`  in  1  serial bit valid; `a` is sampled on an edge where `shift`=1.
- `a`  in  1  serial data bit.
- `start`  in  1  frame realign: clears the bit counter; has no effect on the holding buffer.
- `out`  out  WIDTH  holding-buffer word; stable while `out_valid`=1.
- `out_valid`  out  1  `out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts `out` on an edge where `out_valid` and `out_ready` are both 1.
- `count`  out  CW  bits collected so far in the current word; CW = $clog2(WIDTH+1).
- `overflow`  out  1  sticky; set when a completed word is dropped.

## Operation
- Reset (`reset`=0, asynchronous): shift register, `count`, `out`, `out_valid` and `overflow` all clear to 0.
- Bit capture (`shift`=1):
  - LSB_FIRST=1: the register shifts right and `a` enters bit WIDTH-1.
  - LSB_FIRST=0: the register shifts left and `a` enters bit 0.
  - In both modes, after WIDTH shifts the first received bit sits at the position `LSB_FIRST` defines.
  - `count` increments by 1.
- Word completion: occurs on the shift edge where `count`==WIDTH-1. On that edge:
  - The assembled word, including the current `a`, goes to the holding buffer if the buffer is free at that edge. Free means `out_valid`=0, or `out_valid`=1 with `out_ready`=1.
  - `count` wraps to 0.
- Buffer full at completion (`out_valid`=1, `out_ready`=0):
  - The new word is dropped and `out` is unchanged.
  - `overflow` is set to 1 and stays set until reset.
  - `count` still wraps to 0.
- Consume: on an edge with `out_valid`=1 and `out_ready`=1 and no simultaneous completion, `out_valid` goes to 0 and `out` keeps its last value.
- Consume and completion on the same edge: the new word loads, `out_valid` stays 1, and no overflow is flagged.
- `start`=1:
  - With `shift`=0: `count` goes to 0 and the partial word is discarded.
  - With `shift`=1: the sampled `a` becomes bit 1 of the new frame and `count` goes to 1.
  - `start` never causes a completion in the same cycle, even when `count`==WIDTH-1.
- `shift`=0: the shift register and `count` hold.
- The shift-register contents are never observable directly. Only `out` is.

## Timing
- Latency: `out_valid` rises on the same edge that samples the WIDTH-th bit, so it is visible in the following cycle. Minimum spacing between words is WIDTH cycles.
- Back-to-back words with continuous `shift` and `out_ready`=1 incur no bubbles.
- `out_ready` may be held high with `out_valid`=0; this has no effect.
- `out` is fully registered. No combinational path exists from inputs to outputs.
- Reset asserted mid-word or with a pending word discards all state immediately. Deassertion is synchronised externally by the system reset scheme.

## Structure
- Shared package `sipo_pkg`:
  - `SIPO_MAX_WIDTH` = 64.
  - Function `sipo_cnt_w(width)` returning $clog2(width+1).
  - Both are reused by the future parallel-in/serial-out block.
- Sub-module `sipo_shift_core`: holds the shift register, bit counter, LSB_FIRST steering and the `done` pulse.
- Top level `sipo_word`: holds the holding buffer, handshake and overflow logic.

## Test plan
- Reset mid-word (sequences below use WIDTH=8 unless noted):
  - Stimulus: shift 5 bits, pulse `reset`=0 asynchronously between edges.
  - Required response: `count`=0, `out_valid`=0, `out`=0 immediately; the next 8 bits form a clean word.
- LSB-first assembly:
  - Stimulus: LSB_FIRST=1, `out_ready`=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles.
  - Required response: `out`=8'h4D with `out_valid`=1 for 1 cycle after the 8th edge.
- MSB-first assembly:
  - Stimulus: LSB_FIRST=0, same bit sequence.
  - Required response: `out`=8'hB2.
- Backpressure:
  - Stimulus: `out_ready`=0, shift two full words 8'h4D then 8'hFF.
  - Required response: `out` stays 8'h4D, `overflow`=1 after the 16th bit. Raising `out_ready` then clears `out_valid`; `overflow` stays 1.
- Simultaneous consume and complete:
  - Stimulus: word A pending, `out_ready` asserted on the exact edge word B's last bit arrives.
  - Required response: `out`=B, `out_valid` stays 1, `overflow`=0.
- Realign and width sweep:
  - Stimulus: after 3 bits, assert `start` with `shift`=1 and `a`=1, then 7 more bits; repeat with WIDTH=2 and WIDTH=64 using random data.
  - Required response: realigned word has bit 0 = 1 (LSB_FIRST=1); every sweep word matches the scoreboard and no spurious `overflow` occurs.
